// File: rtl/shift_scheduler_pkg.sv
// Shared constants for the shared-memory switch scheduler slice.
//   PORT_NUB_TOTAL : number of switch ports (slots per frame)
//   DATA_WIDTH     : switch data word width
//   SCHED_*        : 2-bit scheduler FSM state codes
package shift_scheduler_pkg;

  localparam int unsigned PORT_NUB_TOTAL = 8;
  localparam int unsigned DATA_WIDTH     = 32;

  localparam logic [1:0] SCHED_IDLE  = 2'd0;
  localparam logic [1:0] SCHED_RUN   = 2'd1;
  localparam logic [1:0] SCHED_DRAIN = 2'd2;

endpackage

// File: rtl/shift_sched_align.sv
// Registered rotate pipeline that mirrors the barrel shifter, so the valid mask, slot and
// frame marker leave exactly WIDTH_SEL cycles after they enter, rotated like the data.
// Ports:
//   clk      in   1          clock
//   rst_n    in   1          asynchronous active-low reset
//   in_mask  in   PORT_NUB   issued valid mask (input-port order)
//   in_slot  in   WIDTH_SEL  select issued with in_mask
//   in_sop   in   1          frame start marker issued with in_mask
//   out_mask out  PORT_NUB   mask rotated left by in_slot (output-port order)
//   out_slot out  WIDTH_SEL  in_slot delayed WIDTH_SEL cycles
//   out_sop  out  1          in_sop delayed WIDTH_SEL cycles
module shift_sched_align #(
  parameter int unsigned PORT_NUB  = 8,
  parameter int unsigned WIDTH_SEL = $clog2(PORT_NUB)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PORT_NUB-1:0]  in_mask,
  input  logic [WIDTH_SEL-1:0] in_slot,
  input  logic                 in_sop,
  output logic [PORT_NUB-1:0]  out_mask,
  output logic [WIDTH_SEL-1:0] out_slot,
  output logic                 out_sop
);

  // Stage k rotates left by 2^k when select bit k is set; select travels with the mask.
  for (genvar k = 0; k < WIDTH_SEL; k++) begin : g_stage
    localparam int unsigned Sh = 2 ** k;

    logic [PORT_NUB-1:0]  m_in;
    logic [PORT_NUB-1:0]  m_rot;
    logic [WIDTH_SEL-1:0] s_in;
    logic                 p_in;
    logic [PORT_NUB-1:0]  m_q;
    logic [WIDTH_SEL-1:0] s_q;
    logic                 p_q;

    if (k == 0) begin : g_first
      assign m_in = in_mask;
      assign s_in = in_slot;
      assign p_in = in_sop;
    end else begin : g_next
      assign m_in = g_stage[k-1].m_q;
      assign s_in = g_stage[k-1].s_q;
      assign p_in = g_stage[k-1].p_q;
    end

    assign m_rot = s_in[k] ? {m_in[PORT_NUB-1-Sh:0], m_in[PORT_NUB-1:PORT_NUB-Sh]} : m_in;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_q <= '0;
        s_q <= '0;
        p_q <= 1'b0;
      end else begin
        m_q <= m_rot;
        s_q <= s_in;
        p_q <= p_in;
      end
    end
  end

  assign out_mask = g_stage[WIDTH_SEL-1].m_q;
  assign out_slot = g_stage[WIDTH_SEL-1].s_q;
  assign out_sop  = g_stage[WIDTH_SEL-1].p_q;

endmodule

// File: rtl/shift_scheduler.sv
// Barrel shifter sequencer: issues the rotating select, masks incoming valids while running,
// and produces valid mask / slot / frame markers aligned with the shifter output.
// Stops only on frame boundaries and drains the shifter pipeline before going idle.
// Ports:
//   clk       in   1          switch clock
//   rst_n     in   1          asynchronous active-low reset
//   enable    in   1          1 = run, 0 = stop at the next frame boundary
//   in_vld    in   PORT_NUB   per-input-port valid, same cycle as port_in
//   select    out  WIDTH_SEL  barrel shifter select (current slot)
//   busy      out  1          running or draining
//   frame_sop out  1          slot 0 issued this cycle while running
//   out_vld   out  PORT_NUB   per-output-port valid aligned with port_out
//   out_slot  out  WIDTH_SEL  select that produced the current port_out
//   out_sop   out  1          frame_sop aligned with port_out
module shift_scheduler
  import shift_scheduler_pkg::*;
#(
  parameter int unsigned PORT_NUB  = PORT_NUB_TOTAL,
  parameter int unsigned WIDTH_SEL = $clog2(PORT_NUB)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [PORT_NUB-1:0]  in_vld,
  output logic [WIDTH_SEL-1:0] select,
  output logic                 busy,
  output logic                 frame_sop,
  output logic [PORT_NUB-1:0]  out_vld,
  output logic [WIDTH_SEL-1:0] out_slot,
  output logic                 out_sop
);

  localparam logic [WIDTH_SEL-1:0] LastSlot = WIDTH_SEL'(PORT_NUB - 1);
  localparam logic [WIDTH_SEL:0]   Lat      = (WIDTH_SEL + 1)'(WIDTH_SEL);
  localparam logic [WIDTH_SEL:0]   CntOne   = (WIDTH_SEL + 1)'(1);

  logic [1:0]           state_q, state_d;
  logic [WIDTH_SEL-1:0] sel_q, sel_d;
  logic [WIDTH_SEL:0]   cnt_q, cnt_d;
  logic                 run;
  logic [PORT_NUB-1:0]  issued_mask;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    case (state_q)
      SCHED_IDLE: begin
        sel_d = '0;
        if (enable) state_d = SCHED_RUN;
      end
      SCHED_RUN: begin
        // Natural wrap N-1 -> 0 since N is a power of two.
        sel_d = sel_q + 1'b1;
        if ((sel_q == LastSlot) && !enable) begin
          state_d = SCHED_DRAIN;
          cnt_d   = Lat;
        end
      end
      SCHED_DRAIN: begin
        // enable is deliberately ignored until the pipeline is flushed.
        sel_d = '0;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntOne) begin
          state_d = SCHED_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = SCHED_IDLE;
        sel_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SCHED_IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  assign run         = (state_q == SCHED_RUN);
  assign issued_mask = run ? in_vld : '0;
  assign select      = sel_q;
  assign busy        = (state_q != SCHED_IDLE);
  assign frame_sop   = run && (sel_q == '0);

  shift_sched_align #(
    .PORT_NUB  (PORT_NUB),
    .WIDTH_SEL (WIDTH_SEL)
  ) u_align (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_mask  (issued_mask),
    .in_slot  (sel_q),
    .in_sop   (frame_sop),
    .out_mask (out_vld),
    .out_slot (out_slot),
    .out_sop  (out_sop)
  );

endmodule
